// File: rtl/quad_speed_est.sv
// Speed estimator downstream of the quadrature decoder: windowed net step count
// (M-method), step-to-step period (T-method), stall detection and illegal-transition count.
`timescale 1ns/1ps
module quad_speed_est #(
    parameter int WIN_CYCLES     = 100000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int PERIOD_W       = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_pulse,
    input  logic                dir,
    input  logic                illegal,
    input  logic                clear,
    output logic signed [15:0]  win_count,
    output logic                win_valid,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                speed_dir,
    output logic                stalled,
    output logic [7:0]          illegal_cnt
);

    localparam int WIN_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [WIN_W-1:0]    WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] TIMEOUT  = PERIOD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, FIRST, RUN} state_t;

    logic [WIN_W-1:0]    win_cnt_reg;
    logic signed [15:0]  acc_reg;
    logic signed [15:0]  acc_sum;
    logic                win_last;
    logic [PERIOD_W-1:0] per_cnt_reg;
    state_t              state_reg, state_next;
    logic [PERIOD_W-1:0] period_next;
    logic                dir_next;

    assign win_last = (win_cnt_reg == WIN_LAST);

    // Saturating accumulate of this cycle's step; also feeds the closing window value
    always_comb begin
        acc_sum = acc_reg;
        if (step_pulse) begin
            if (dir && acc_reg != 16'sh7FFF)
                acc_sum = acc_reg + 16'sd1;
            else if (!dir && acc_reg != 16'sh8000)
                acc_sum = acc_reg - 16'sd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_reg <= '0;
            acc_reg     <= '0;
            win_count   <= '0;
            win_valid   <= 1'b0;
        end else if (clear) begin
            win_cnt_reg <= '0;
            acc_reg     <= '0;
            win_count   <= '0;
            win_valid   <= 1'b0;
        end else begin
            win_valid <= win_last;
            if (win_last) begin
                win_cnt_reg <= '0;
                win_count   <= acc_sum;
                acc_reg     <= '0;
            end else begin
                win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                acc_reg     <= acc_sum;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        period_next = period;
        dir_next    = speed_dir;
        case (state_reg)
            IDLE: begin
                if (step_pulse) begin
                    state_next = FIRST;
                    dir_next   = dir;
                end
            end
            FIRST, RUN: begin
                // A step always beats a coincident timeout
                if (step_pulse) begin
                    if (dir == speed_dir) begin
                        state_next  = RUN;
                        period_next = per_cnt_reg;
                    end else begin
                        state_next  = FIRST;
                        period_next = '0;
                        dir_next    = dir;
                    end
                end else if (per_cnt_reg == TIMEOUT) begin
                    state_next  = IDLE;
                    period_next = '0;
                end
            end
            default: begin
                state_next  = IDLE;
                period_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            per_cnt_reg  <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            speed_dir    <= 1'b0;
            stalled      <= 1'b1;
        end else if (clear) begin
            state_reg    <= IDLE;
            per_cnt_reg  <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            speed_dir    <= 1'b0;
            stalled      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            period       <= period_next;
            speed_dir    <= dir_next;
            period_valid <= (state_next == RUN);
            stalled      <= (state_next == IDLE);
            if (step_pulse)
                per_cnt_reg <= PERIOD_W'(1);
            else if (per_cnt_reg != '1)
                per_cnt_reg <= per_cnt_reg + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt <= '0;
        else if (clear)
            illegal_cnt <= '0;
        else if (illegal && illegal_cnt != 8'hFF)
            illegal_cnt <= illegal_cnt + 8'd1;
    end

endmodule

// File: tb/tb_quad_speed_est.sv
// Directed bench for quad_speed_est with a short window and timeout.
`timescale 1ns/1ps
module tb_quad_speed_est;

    localparam int WIN = 100;
    localparam int TMO = 1000;
    localparam int PW  = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              step_pulse = 1'b0;
    logic              dir = 1'b0;
    logic              illegal = 1'b0;
    logic              clear = 1'b0;
    logic signed [15:0] win_count;
    logic              win_valid;
    logic [PW-1:0]     period;
    logic              period_valid;
    logic              speed_dir;
    logic              stalled;
    logic [7:0]        illegal_cnt;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    quad_speed_est #(
        .WIN_CYCLES(WIN),
        .TIMEOUT_CYCLES(TMO),
        .PERIOD_W(PW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .step_pulse(step_pulse),
        .dir(dir),
        .illegal(illegal),
        .clear(clear),
        .win_count(win_count),
        .win_valid(win_valid),
        .period(period),
        .period_valid(period_valid),
        .speed_dir(speed_dir),
        .stalled(stalled),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("t=%0t %s observed=%0d expected=%0d", $time, tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic step(input logic d, input int gap);
        step_pulse = 1'b1;
        dir        = d;
        tick();
        step_pulse = 1'b0;
        repeat (gap - 1) tick();
    endtask

    // Advance until the next edge to be sampled has window phase p
    task automatic wait_phase(input int p);
        while (edge_n % WIN != p) tick();
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_win_count"}, 32'(win_count), 0);
        chk({pfx, "_win_valid"}, 32'(win_valid), 0);
        chk({pfx, "_period"}, 32'(period), 0);
        chk({pfx, "_period_valid"}, 32'(period_valid), 0);
        chk({pfx, "_speed_dir"}, 32'(speed_dir), 0);
        chk({pfx, "_stalled"}, 32'(stalled), 1);
        chk({pfx, "_illegal_cnt"}, 32'(illegal_cnt), 0);
    endtask

    initial begin
        #12;
        chk_reset_state("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        edge_n = 0;

        // T1: ten CW steps 7 cycles apart inside the first window
        for (int i = 0; i < 10; i++) step(1'b1, 7);
        chk("t1_period", 32'(period), 7);
        chk("t1_period_valid", 32'(period_valid), 1);
        chk("t1_stalled", 32'(stalled), 0);
        chk("t1_speed_dir", 32'(speed_dir), 1);
        wait_phase(99);
        chk("t1_valid_before", 32'(win_valid), 0);
        tick();
        chk("t1_win_valid", 32'(win_valid), 1);
        chk("t1_win_count", 32'(win_count), 10);
        tick();
        chk("t1_valid_after", 32'(win_valid), 0);

        // T2: direction reversal
        for (int i = 0; i < 3; i++) step(1'b1, 5);
        chk("t2_cw_period", 32'(period), 5);
        chk("t2_cw_valid", 32'(period_valid), 1);
        step(1'b0, 5);
        chk("t2_rev_period", 32'(period), 0);
        chk("t2_rev_valid", 32'(period_valid), 0);
        chk("t2_rev_dir", 32'(speed_dir), 0);
        step(1'b0, 5);
        chk("t2_acw_period", 32'(period), 5);
        chk("t2_acw_valid", 32'(period_valid), 1);
        step(1'b0, 5);
        wait_phase(99);
        tick();
        chk("t2_win_valid", 32'(win_valid), 1);
        chk("t2_win_count", 32'(win_count), 0);

        // T3: single step then stall at exactly TMO cycles
        step_pulse = 1'b1;
        dir        = 1'b0;
        tick();
        step_pulse = 1'b0;
        repeat (TMO - 1) tick();
        chk("t3_stalled_early", 32'(stalled), 0);
        tick();
        chk("t3_stalled", 32'(stalled), 1);
        chk("t3_period", 32'(period), 0);
        chk("t3_period_valid", 32'(period_valid), 0);
        step(1'b1, 4);
        chk("t3_first_stalled", 32'(stalled), 0);
        chk("t3_first_valid", 32'(period_valid), 0);
        chk("t3_first_period", 32'(period), 0);
        chk("t3_first_dir", 32'(speed_dir), 1);
        step(1'b1, 4);
        chk("t3_run_period", 32'(period), 4);
        chk("t3_run_valid", 32'(period_valid), 1);

        // T4: step in the terminal window cycle
        wait_phase(99);
        tick();
        wait_phase(50);
        step_pulse = 1'b1;
        dir        = 1'b1;
        tick();
        step_pulse = 1'b0;
        wait_phase(99);
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        chk("t4_win_valid", 32'(win_valid), 1);
        chk("t4_win_count", 32'(win_count), 2);
        chk("t4_period", 32'(period), 49);
        wait_phase(99);
        tick();
        chk("t4_next_valid", 32'(win_valid), 1);
        chk("t4_next_count", 32'(win_count), 0);

        // T5: illegal saturation, coincident step, then clear
        step_pulse = 1'b1;
        dir        = 1'b1;
        illegal    = 1'b1;
        tick();
        step_pulse = 1'b0;
        illegal    = 1'b0;
        chk("t5_ill_first", 32'(illegal_cnt), 1);
        chk("t5_coinc_valid", 32'(period_valid), 1);
        tick();
        for (int i = 1; i < 254; i++) begin
            illegal = 1'b1;
            tick();
            illegal = 1'b0;
            tick();
        end
        chk("t5_ill_254", 32'(illegal_cnt), 254);
        illegal = 1'b1;
        tick();
        illegal = 1'b0;
        tick();
        chk("t5_ill_255", 32'(illegal_cnt), 255);
        for (int i = 0; i < 45; i++) begin
            illegal = 1'b1;
            tick();
            illegal = 1'b0;
            tick();
        end
        chk("t5_ill_sat", 32'(illegal_cnt), 255);
        wait_phase(0);
        for (int i = 0; i < 3; i++) step(1'b1, 5);
        chk("t5_period", 32'(period), 5);
        wait_phase(99);
        tick();
        chk("t5_win_count", 32'(win_count), 3);
        clear      = 1'b1;
        step_pulse = 1'b1;
        dir        = 1'b1;
        illegal    = 1'b1;
        tick();
        clear      = 1'b0;
        step_pulse = 1'b0;
        illegal    = 1'b0;
        edge_n     = 0;
        chk_reset_state("clear");
        wait_phase(99);
        chk("clear_valid_before", 32'(win_valid), 0);
        tick();
        chk("clear_win_valid", 32'(win_valid), 1);
        chk("clear_win_count", 32'(win_count), 0);

        // T6: asynchronous reset while in RUN
        step(1'b1, 5);
        step(1'b1, 5);
        chk("t6_pre_valid", 32'(period_valid), 1);
        chk("t6_pre_period", 32'(period), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_period", 32'(period), 0);
        chk("t6_async_valid", 32'(period_valid), 0);
        chk("t6_async_stalled", 32'(stalled), 1);
        chk("t6_async_dir", 32'(speed_dir), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        edge_n = 0;
        step(1'b1, 3);
        chk("t6_first_valid", 32'(period_valid), 0);
        chk("t6_first_stalled", 32'(stalled), 0);
        chk("t6_first_period", 32'(period), 0);
        step(1'b1, 3);
        chk("t6_run_period", 32'(period), 3);
        chk("t6_run_valid", 32'(period_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
